// File: rtl/principal_decoder.sv
// Principal instruction decoder for the single-cycle ARM-subset CPU.
// Decodes Op/I/L into datapath controls, registered with an async active-high reset.
module principal_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic       I,
    input  logic       L,
    output logic [1:0] InmSrc,
    output logic [1:0] RegSrc,
    output logic       ALUSrc,
    output logic       Branch,
    output logic       MemWR,
    output logic       RegWR,
    output logic       MemtoReg,
    output logic       ALUOp
);

    // Control word layout: InmSrc RegSrc ALUSrc Branch MemWR RegWR MemtoReg ALUOp
    localparam logic [9:0] CTRL_DP_REG = 10'b00_00_0_0_0_1_0_1;
    localparam logic [9:0] CTRL_DP_IMM = 10'b00_00_1_0_0_1_0_1;
    localparam logic [9:0] CTRL_STR    = 10'b01_10_1_0_1_0_0_0;
    localparam logic [9:0] CTRL_LDR    = 10'b01_00_1_0_0_1_1_0;
    localparam logic [9:0] CTRL_BRANCH = 10'b10_01_1_1_0_0_0_0;
    localparam logic [9:0] CTRL_NONE   = 10'b00_00_0_0_0_0_0_0;

    logic [9:0] ctrl_d;
    logic [9:0] ctrl_q;

    // Any Op encoding outside the three defined classes falls to the all-zero row.
    always_comb begin
        ctrl_d = CTRL_NONE;
        case (Op)
            2'b00:   ctrl_d = (I == 1'b1) ? CTRL_DP_IMM : CTRL_DP_REG;
            2'b01:   ctrl_d = (L == 1'b1) ? CTRL_LDR : CTRL_STR;
            2'b10:   ctrl_d = CTRL_BRANCH;
            default: ctrl_d = CTRL_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= CTRL_NONE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign InmSrc   = ctrl_q[9:8];
    assign RegSrc   = ctrl_q[7:6];
    assign ALUSrc   = ctrl_q[5];
    assign Branch   = ctrl_q[4];
    assign MemWR    = ctrl_q[3];
    assign RegWR    = ctrl_q[2];
    assign MemtoReg = ctrl_q[1];
    assign ALUOp    = ctrl_q[0];

endmodule

// File: tb/tb_principal_decoder.sv
// Self-checking bench for principal_decoder: rule-based reference model,
// per-cycle compare, directed literal rows, latency/reset checks and random stimulus.
module tb_principal_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic       I;
    logic       L;
    logic [1:0] InmSrc;
    logic [1:0] RegSrc;
    logic       ALUSrc;
    logic       Branch;
    logic       MemWR;
    logic       RegWR;
    logic       MemtoReg;
    logic       ALUOp;

    int checks   = 0;
    int failures = 0;
    bit cmpEnable = 1'b0;
    logic [9:0] expCtrl = '0;

    principal_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .I        (I),
        .L        (L),
        .InmSrc   (InmSrc),
        .RegSrc   (RegSrc),
        .ALUSrc   (ALUSrc),
        .Branch   (Branch),
        .MemWR    (MemWR),
        .RegWR    (RegWR),
        .MemtoReg (MemtoReg),
        .ALUOp    (ALUOp)
    );

    always #5 clk = ~clk;

    wire [9:0] dutCtrl = {InmSrc, RegSrc, ALUSrc, Branch, MemWR, RegWR, MemtoReg, ALUOp};

    // Reference model: each output derived from the instruction class rules.
    function automatic logic [9:0] modelDecode(input logic [1:0] op, input logic i, input logic l);
        bit isDp, isMem, isBr, isLdr, isStr;
        logic [1:0] inm, rsrc;
        logic aluSrc, br, memWr, regWr, memToReg, aluOp;
        isDp  = (op == 2'd0);
        isMem = (op == 2'd1);
        isBr  = (op == 2'd2);
        isLdr = isMem && l;
        isStr = isMem && !l;
        inm      = isDp ? 2'd0 : (isMem ? 2'd1 : (isBr ? 2'd2 : 2'd0));
        rsrc     = {isStr, isBr};
        aluSrc   = (isDp && i) || isMem || isBr;
        br       = isBr;
        memWr    = isStr;
        regWr    = isDp || isLdr;
        memToReg = isLdr;
        aluOp    = isDp;
        return {inm, rsrc, aluSrc, br, memWr, regWr, memToReg, aluOp};
    endfunction

    task automatic checkOutput(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%b expected=%b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected registered word tracks the rising edge, cleared asynchronously by reset.
    always @(posedge clk or posedge reset) begin
        if (reset) expCtrl = '0;
        else       expCtrl = modelDecode(Op, I, L);
    end

    always @(negedge clk) begin
        if (cmpEnable) checkOutput("cycle", dutCtrl, expCtrl);
    end

    // Change inputs mid-cycle and confirm outputs hold until the next rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic i, input logic l);
        @(negedge clk);
        #2;
        Op = op;
        I  = i;
        L  = l;
        #1;
        checkOutput("hold_before_edge", dutCtrl, expCtrl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        Op = 2'd0;
        I  = 1'b1;
        L  = 1'b0;
        #1;
        checkOutput("reset_initial", dutCtrl, 10'b0);

        @(negedge clk);
        reset = 1'b0;
        cmpEnable = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("dp_imm_after_reset", dutCtrl, 10'b00_00_1_0_0_1_0_1);

        // Mid-cycle reset clears outputs without waiting for a clock edge.
        #1;
        reset = 1'b1;
        #1;
        checkOutput("reset_async_clear", dutCtrl, 10'b0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release_load", dutCtrl, 10'b00_00_1_0_0_1_0_1);

        applyStimulus(2'd0, 1'b0, 1'b0);
        checkOutput("dp_reg", dutCtrl, 10'b00_00_0_0_0_1_0_1);
        applyStimulus(2'd0, 1'b1, 1'b0);
        checkOutput("dp_imm", dutCtrl, 10'b00_00_1_0_0_1_0_1);
        applyStimulus(2'd1, 1'b0, 1'b0);
        checkOutput("str", dutCtrl, 10'b01_10_1_0_1_0_0_0);
        applyStimulus(2'd1, 1'b0, 1'b1);
        checkOutput("ldr", dutCtrl, 10'b01_00_1_0_0_1_1_0);
        applyStimulus(2'd2, 1'b0, 1'b0);
        checkOutput("branch", dutCtrl, 10'b10_01_1_1_0_0_0_0);
        applyStimulus(2'd3, 1'b1, 1'b1);
        checkOutput("undef_i1_l1", dutCtrl, 10'b0);
        applyStimulus(2'd0, 1'b1, 1'b1);
        checkOutput("dp_imm_l_ignored", dutCtrl, 10'b00_00_1_0_0_1_0_1);
        applyStimulus(2'd1, 1'b1, 1'b1);
        checkOutput("ldr_i_ignored", dutCtrl, 10'b01_00_1_0_0_1_1_0);
        applyStimulus(2'd2, 1'b1, 1'b1);
        checkOutput("branch_il_ignored", dutCtrl, 10'b10_01_1_1_0_0_0_0);
        applyStimulus(2'd3, 1'b0, 1'b0);
        checkOutput("undef_i0_l0", dutCtrl, 10'b0);

        checkOutput("model_str_pin", modelDecode(2'd1, 1'b1, 1'b0), 10'b01_10_1_0_1_0_0_0);
        checkOutput("model_undef_pin", modelDecode(2'd3, 1'b1, 1'b1), 10'b0);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            checks++;
            if (MemWR && RegWR) begin
                failures++;
                $display("[TB] FAIL memwr_regwr_exclusive: MemWR=%b RegWR=%b required not both 1", MemWR, RegWR);
            end
            if ($urandom_range(0, 15) == 0) begin
                #1;
                reset = 1'b1;
                #1;
                checkOutput("random_reset_clear", dutCtrl, 10'b0);
                #1;
                reset = 1'b0;
            end
        end

        @(negedge clk);
        cmpEnable = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
